// File: rtl/mvmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvmul_pkg
//  Description : Shared types and constants for the mvmul compute slice:
//                FSM state encoding, default geometry, base-address helpers
//                and phase lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mvmul_pkg;

    // Default geometry of the kernel and of its scratch RAM.
    localparam int c_N_DEFAULT      = 3;
    localparam int c_WIDTH_DEFAULT  = 32;
    localparam int c_AWIDTH_DEFAULT = 5;

    // Fixed phase lengths. DRAIN lets the last product reach the
    // accumulator; FLUSH covers the RAM's write delay stage plus the array
    // write of the final result.
    localparam int c_DRAIN_CYCLES = 2;
    localparam int c_FLUSH_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } mvmul_state_e;

    // Default memory map: A row-major at 0, x right after A, y right after x.
    function automatic int mvmul_x_base(input int n);
        return n * n;
    endfunction

    function automatic int mvmul_y_base(input int n);
        return n * n + n;
    endfunction

endpackage : mvmul_pkg
`default_nettype wire

// File: rtl/mvmul_if.sv
`default_nettype none
// ============================================================================
//  Module      : mvmul_if
//  Description : Bundle between the mvmul kernel and the 2R/1W scratch RAM.
//                master = kernel, slave = RAM.
//  Signals     : raddr_0/rdata_0 - A element read port (1-cycle latency)
//                raddr_1/rdata_1 - x element read port (1-cycle latency)
//                waddr_0/wdata_0/wen_0 - y write port
//                valid - all results committed (sticky until reset)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mvmul_if
    import mvmul_pkg::*;
#(
    parameter int WIDTH  = c_WIDTH_DEFAULT,
    parameter int AWIDTH = c_AWIDTH_DEFAULT
);

    logic [AWIDTH-1:0] raddr_0;
    logic [WIDTH-1:0]  rdata_0;
    logic [AWIDTH-1:0] raddr_1;
    logic [WIDTH-1:0]  rdata_1;
    logic [AWIDTH-1:0] waddr_0;
    logic [WIDTH-1:0]  wdata_0;
    logic              wen_0;
    logic              valid;

    modport master (
        output raddr_0, raddr_1, waddr_0, wdata_0, wen_0, valid,
        input  rdata_0, rdata_1
    );

    modport slave (
        input  raddr_0, raddr_1, waddr_0, wdata_0, wen_0, valid,
        output rdata_0, rdata_1
    );

endinterface : mvmul_if
`default_nettype wire

// File: rtl/mvmul_mac.sv
`default_nettype none
// ============================================================================
//  Module      : mvmul_mac
//  Description : Registered unsigned multiply-accumulate. i_clr has priority
//                over i_en. Without MVMUL_CORE_SAT_EN the product is
//                truncated and the sum wraps mod 2^WIDTH; with
//                MVMUL_CORE_SAT_EN both saturate at 2^WIDTH-1.
//  Ports       : clk, rst (sync, active-low)
//                i_clr - clear accumulator
//                i_en  - accumulate i_a*i_b
//                i_a, i_b - operands
//                o_acc - accumulator value
//  Macro       : MVMUL_CORE_SAT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module mvmul_mac #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_acc
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_acc_next;

`ifdef MVMUL_CORE_SAT_EN
    logic [2*WIDTH-1:0] w_prod_full;
    logic [WIDTH:0]     w_sum;

    assign w_prod_full = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign w_prod      = (|w_prod_full[2*WIDTH-1:WIDTH]) ? '1 : w_prod_full[WIDTH-1:0];
    assign w_sum       = {1'b0, acc_q} + {1'b0, w_prod};
    // Once at the ceiling, any further non-negative term keeps it there.
    assign w_acc_next  = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
    assign w_prod      = i_a * i_b;
    assign w_acc_next  = acc_q + w_prod;
`endif

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule : mvmul_mac
`default_nettype wire

// File: rtl/mvmul_core.sv
`default_nettype none
// ============================================================================
//  Module      : mvmul_core
//  Description : y = A*x kernel over a 2R/1W scratch RAM. Streams each row
//                of A together with x through the read ports, accumulates
//                in mvmul_mac, writes one result per row and raises a sticky
//                valid once the last result has been committed by the RAM.
//  Ports       : clk            - clock, rising edge
//                rst            - synchronous, active-low reset
//                bus (master)   - raddr_0/rdata_0 (A), raddr_1/rdata_1 (x),
//                                 waddr_0/wdata_0/wen_0 (y), valid
//  Macro       : MVMUL_CORE_SAT_EN - saturating product/accumulate in the MAC
//  Revision    : 1.0 - initial release
// ============================================================================
module mvmul_core
    import mvmul_pkg::*;
#(
    parameter int N      = c_N_DEFAULT,
    parameter int WIDTH  = c_WIDTH_DEFAULT,
    parameter int AWIDTH = c_AWIDTH_DEFAULT,
    parameter int A_BASE = 0,
    parameter int X_BASE = mvmul_x_base(N),
    parameter int Y_BASE = mvmul_y_base(N)
) (
    input  wire logic clk,
    input  wire logic rst,
    mvmul_if.master   bus
);

    // One counter serves ISSUE columns, DRAIN and FLUSH cycles.
    localparam int c_CNT_MAX = (N > c_DRAIN_CYCLES) ? N : c_DRAIN_CYCLES;
    localparam int CW        = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int RW        = (N > 1) ? $clog2(N) : 1;

    generate
        if (Y_BASE + N > (1 << AWIDTH)) begin : g_cfg_check
            $error("mvmul_core: result vector does not fit the RAM address space");
        end
    endgenerate

    mvmul_state_e      state_q,   state_d;
    logic [RW-1:0]     row_q,     row_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [AWIDTH-1:0] raddr_0_q, raddr_0_d;
    logic [AWIDTH-1:0] raddr_1_q, raddr_1_d;
    logic [AWIDTH-1:0] waddr_q,   waddr_d;
    logic [WIDTH-1:0]  wdata_q,   wdata_d;
    logic              wen_q,     wen_d;
    logic              valid_q,   valid_d;
    // High in the cycle the RAM returns data for an address issued in ISSUE,
    // i.e. the accumulate window.
    logic              rd_vld_q,  rd_vld_d;

    logic [WIDTH-1:0]  w_acc;
    logic              w_mac_clr;

    function automatic logic [AWIDTH-1:0] a_addr(input logic [RW-1:0] r,
                                                 input logic [CW-1:0] c);
        return AWIDTH'(A_BASE + int'(r) * N + int'(c));
    endfunction

    function automatic logic [AWIDTH-1:0] x_addr(input logic [CW-1:0] c);
        return AWIDTH'(X_BASE + int'(c));
    endfunction

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        raddr_0_d = raddr_0_q;
        raddr_1_d = raddr_1_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        valid_d   = valid_q;
        rd_vld_d  = (state_q == ST_ISSUE);

        unique case (state_q)
            ST_IDLE: begin
                // Leaving IDLE registers column 0 of row 0.
                state_d   = ST_ISSUE;
                row_d     = '0;
                cnt_d     = '0;
                raddr_0_d = a_addr('0, '0);
                raddr_1_d = x_addr('0);
            end
            ST_ISSUE: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    raddr_0_d = a_addr(row_q, cnt_q + 1'b1);
                    raddr_1_d = x_addr(cnt_q + 1'b1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(c_DRAIN_CYCLES - 1)) begin
                    // The last product landed on the previous edge.
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                    wen_d   = 1'b1;
                    waddr_d = AWIDTH'(Y_BASE + int'(row_q));
                    wdata_d = w_acc;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                cnt_d = '0;
                if (row_q == RW'(N - 1)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d   = ST_ISSUE;
                    row_d     = row_q + 1'b1;
                    raddr_0_d = a_addr(row_q + 1'b1, '0);
                    raddr_1_d = x_addr('0);
                end
            end
            ST_FLUSH: begin
                // valid goes up on the edge the RAM commits the last result,
                // which is the start of the final FLUSH cycle.
                if (cnt_q == CW'(c_FLUSH_CYCLES - 2)) begin
                    valid_d = 1'b1;
                end
                if (cnt_q == CW'(c_FLUSH_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            cnt_q     <= '0;
            raddr_0_q <= '0;
            raddr_1_q <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            valid_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            raddr_0_q <= raddr_0_d;
            raddr_1_q <= raddr_1_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            valid_q   <= valid_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Clearing on the edge that leaves WRITE (or IDLE) starts each row from
    // zero before its first product arrives two edges later.
    assign w_mac_clr = (state_q == ST_IDLE) || (state_q == ST_WRITE);

    mvmul_mac #(
        .WIDTH (WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_mac_clr),
        .i_en  (rd_vld_q),
        .i_a   (bus.rdata_0),
        .i_b   (bus.rdata_1),
        .o_acc (w_acc)
    );

    assign bus.raddr_0 = raddr_0_q;
    assign bus.raddr_1 = raddr_1_q;
    assign bus.waddr_0 = waddr_q;
    assign bus.wdata_0 = wdata_q;
    assign bus.wen_0   = wen_q;
    assign bus.valid   = valid_q;

endmodule : mvmul_core
`default_nettype wire

// File: tb/tb_mvmul_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvmul_core
//  Description : Bench for mvmul_core with a behavioural 2R/1W RAM (1-cycle
//                read latency, 1-cycle internal write delay). Expected
//                results come from plain arithmetic over the loaded A and x;
//                expected output timing comes from the row/phase schedule.
//  Macro       : MVMUL_CORE_SAT_EN - selects saturating expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvmul_core;
    import mvmul_pkg::*;

    localparam int N         = 3;
    localparam int WIDTH     = 32;
    localparam int AWIDTH    = 5;
    localparam int A_BASE    = 0;
    localparam int X_BASE    = N * N;
    localparam int Y_BASE    = N * N + N;
    localparam int ROW_EDGES = N + 3;
    localparam int RUN_EDGES = N * ROW_EDGES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mvmul_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    mvmul_core #(
        .N(N), .WIDTH(WIDTH), .AWIDTH(AWIDTH),
        .A_BASE(A_BASE), .X_BASE(X_BASE), .Y_BASE(Y_BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------ RAM model
    logic [WIDTH-1:0]  mem [0:31];
    logic              ld_en   = 1'b0;
    logic [AWIDTH-1:0] ld_addr = '0;
    logic [WIDTH-1:0]  ld_data = '0;
    logic              wq_en   = 1'b0;
    logic [AWIDTH-1:0] wq_addr = '0;
    logic [WIDTH-1:0]  wq_data = '0;

    always @(posedge clk) begin
        bus.rdata_0 <= mem[bus.raddr_0];
        bus.rdata_1 <= mem[bus.raddr_1];
        wq_en       <= bus.wen_0;
        wq_addr     <= bus.waddr_0;
        wq_data     <= bus.wdata_0;
        if (wq_en) mem[wq_addr] <= wq_data;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // Index of the latest edge that sampled rst=1 (-1 after a reset edge).
    int last_edge = -2;
    always @(posedge clk) begin
        if (!rst)                 last_edge <= -1;
        else if (last_edge >= -1) last_edge <= last_edge + 1;
    end

    // ------------------------------------------------------------ model
    logic [WIDTH-1:0] ta [0:N*N-1];
    logic [WIDTH-1:0] tx [0:N-1];
    logic [WIDTH-1:0] exp_y [0:N-1];
    logic [WIDTH-1:0] lit_y [0:N-1];
    bit               lit_en = 1'b0;
    int               lit_wen_edge [0:N-1] = '{5, 11, 17};

    function automatic logic [WIDTH-1:0] model_row(input int i);
        logic [63:0] acc;
        logic [63:0] p;
        logic [63:0] top;
        acc = 0;
        top = 64'h0000_0000_FFFF_FFFF;
        for (int j = 0; j < N; j++) begin
            p = 64'(ta[i*N+j]) * 64'(tx[j]);
`ifdef MVMUL_CORE_SAT_EN
            if (p > top) p = top;
            acc = acc + p;
            if (acc > top) acc = top;
`else
            acc = (acc + p) & top;
`endif
        end
        return acc[WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------ checking
    int n_chk  = 0;
    int n_fail = 0;
    int final_req = 0;
    int final_ack = 0;
    int wen_cnt = 0;
    int wen_edge [0:7];
    int valid_rise = -1;
    int e, row, ph;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d, t=%0t)",
                     name, act, exp, last_edge, $time);
        end
    endtask

    always @(negedge clk) begin
        if (last_edge == -1) begin
            check("idle_raddr_0", 64'(bus.raddr_0), 64'(0));
            check("idle_raddr_1", 64'(bus.raddr_1), 64'(0));
            check("idle_waddr_0", 64'(bus.waddr_0), 64'(0));
            check("idle_wdata_0", 64'(bus.wdata_0), 64'(0));
            check("idle_wen_0",   64'(bus.wen_0),   64'(0));
            check("idle_valid",   64'(bus.valid),   64'(0));
            wen_cnt    = 0;
            valid_rise = -1;
        end else if (last_edge >= 0) begin
            e   = last_edge;
            row = e / ROW_EDGES;
            ph  = e % ROW_EDGES;
            if (e < RUN_EDGES && ph < N) begin
                check("issue_raddr_0", 64'(bus.raddr_0), 64'(A_BASE + row*N + ph));
                check("issue_raddr_1", 64'(bus.raddr_1), 64'(X_BASE + ph));
            end
            if (e >= RUN_EDGES + 2) begin
                check("done_raddr_0_held", 64'(bus.raddr_0), 64'(A_BASE + N*N - 1));
                check("done_raddr_1_held", 64'(bus.raddr_1), 64'(X_BASE + N - 1));
            end
            if (e < RUN_EDGES && ph == N + 2) begin
                check("wen_0_pulse", 64'(bus.wen_0),   64'(1));
                check("waddr_0",     64'(bus.waddr_0), 64'(Y_BASE + row));
                check("wdata_0",     64'(bus.wdata_0), 64'(exp_y[row]));
            end else begin
                check("wen_0_quiet", 64'(bus.wen_0), 64'(0));
            end
            check("valid", 64'(bus.valid), 64'(e >= RUN_EDGES + 1));
            if (bus.wen_0 === 1'b1) begin
                if (wen_cnt < 8) wen_edge[wen_cnt] = e;
                wen_cnt++;
            end
            if (bus.valid === 1'b1 && valid_rise < 0) valid_rise = e;
        end

        if (final_req != final_ack) begin
            final_ack = final_req;
            for (int i = 0; i < N; i++) begin
                check("y_model", 64'(mem[Y_BASE+i]), 64'(exp_y[i]));
                if (lit_en) check("y_literal", 64'(mem[Y_BASE+i]), 64'(lit_y[i]));
            end
            check("mem15_untouched", 64'(mem[15]), 64'h0000_0000_DEAD_BEEF);
            check("wen_pulse_count", 64'(wen_cnt), 64'(N));
            for (int k = 0; k < N && k < wen_cnt; k++)
                check("wen_pulse_edge", 64'(wen_edge[k]), 64'(lit_wen_edge[k]));
            check("valid_rise_edge", 64'(valid_rise), 64'(19));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic load(input int addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AWIDTH'(addr);
        ld_data = data;
    endtask

    task automatic set_lit(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                           input logic [WIDTH-1:0] l2);
        lit_en   = 1'b1;
        lit_y[0] = l0;
        lit_y[1] = l1;
        lit_y[2] = l2;
    endtask

    task automatic run_test(input int hold, input int abort_at);
        int guard;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N*N; i++) load(A_BASE + i, ta[i]);
        for (int j = 0; j < N; j++)   load(X_BASE + j, tx[j]);
        for (int i = 0; i < N; i++)   load(Y_BASE + i, 32'hA5A5_A5A5);
        for (int i = 0; i < N; i++)   exp_y[i] = model_row(i);
        @(negedge clk);
        ld_en = 1'b0;
        rst   = 1'b1;
        if (abort_at >= 0) begin
            guard = 0;
            while (last_edge != abort_at - 1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end
        guard = 0;
        while (bus.valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (hold) @(negedge clk);
        final_req++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) load(i, '0);
        load(15, 32'hDEAD_BEEF);

        // 1: worked example
        ta = '{6, 1, 2, 3, 7, 5, 5, 2, 9};
        tx = '{9, 3, 7};
        set_lit(71, 83, 114);
        run_test(4, -1);

        // 2: identity
        ta = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tx = '{4, 5, 6};
        set_lit(4, 5, 6);
        run_test(4, -1);

        // 3: overflowing products
        for (int i = 0; i < N*N; i++) ta[i] = 32'h0001_0000;
        for (int j = 0; j < N; j++)   tx[j] = 32'h0001_0000;
`ifdef MVMUL_CORE_SAT_EN
        set_lit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        set_lit(0, 0, 0);
`endif
        run_test(4, -1);

        // 4: reset at edge 8, then full rerun of the worked example
        ta = '{6, 1, 2, 3, 7, 5, 5, 2, 9};
        tx = '{9, 3, 7};
        set_lit(71, 83, 114);
        run_test(4, 8);

        // 5: zero matrix, valid held for a long time
        for (int i = 0; i < N*N; i++) ta[i] = '0;
        tx = '{11, 22, 33};
        set_lit(0, 0, 0);
        run_test(120, -1);

        // Reset after the hold: outputs must drop to zero.
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mvmul_core
`default_nettype wire
